sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Slave end of the core's sram bus: an on-chip word memory that answers ibus/dbus requests from the memory-management stage.
- Serves simulation benches and small FPGA builds in place of external memory.
- Accepts pipelined requests, queues them in order and returns each response a fixed number of cycles after acceptance.
- Flags misaligned, out-of-range or illegal-size accesses with an error response.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words in the store. Power of two.
- LATENCY, 2: cycles from acceptance to data_ok. Must be >= 1.
- QUEUE, 4: maximum number of outstanding accepted requests. Must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low
- req  input  1  master request valid
- wr  input  1  1 = write, 0 = read
- size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- addr  input  32  byte address
- wdata  input  32  write data, lane-aligned to addr[1:0]
- addr_ok  output  1  request accepted this cycle when req & addr_ok
- data_ok  output  1  one-cycle response strobe
- rdata  output  32  full read word, valid with data_ok
- err  output  1  error flag for the response, valid with data_ok

Behaviour:
- Reset (rst low), asynchronous:
  - queue flushed; addr_ok, data_ok and err = 0; rdata = 0.
  - Memory contents are not cleared.
  - Pending responses are discarded and their writes are never committed.
  - Outputs remain in the reset state until the first edge after rst rises.
- Accept:
  - addr_ok = (occupancy < QUEUE). Depends only on registered occupancy, so there is no combinational path from req.
  - req & addr_ok in cycle T enqueues {wr, size, addr, wdata, error class} with a countdown of LATENCY.
  - With the queue full, no request is accepted even if the head pops in the same cycle.
- Countdown:
  - Every queued entry decrements by 1 per cycle, saturating at 0.
  - The entries are in-order, so the head always reaches 0 first.
- Response:
  - When the head countdown is 0, in cycle T+LATENCY at the earliest, data_ok = 1 for exactly one cycle and the head pops.
  - Back-to-back responses are allowed, one per cycle.
  - rdata and err are registered and driven in the same cycle as data_ok.
  - rdata and err hold their last values while data_ok = 0.
- Error classes, evaluated at accept:
  - size == 3
  - size == 1 with addr[0] = 1
  - size == 2 with addr[1:0] != 0
  - addr[31:2] >= DEPTH_WORDS
- Error response: data_ok = 1, err = 1, rdata = 0, memory untouched.
- Read: rdata = the full word at addr[31:2]. The master extracts lanes.
- Write:
  - Committed at response time, in the data_ok cycle.
  - Byte enables: byte selects lane addr[1:0]; half selects lanes {addr[1],0} and {addr[1],1}; word selects all lanes.
  - rdata = 0 on writes.
- Ordering:
  - Commit at pop plus in-order service makes read-after-write to the same address return the new data, including back-to-back with LATENCY = 1.
- Simultaneous accept and pop in one cycle: occupancy unchanged.
- Queue pointers are log2(QUEUE)-bit with wrap-around; occupancy is a separate counter 0..QUEUE.

Optional Feature:
- Macro: SRAM_RESPONDER_STALL_EN
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reloaded on reset) steps every cycle.
  - When LFSR[0] = 1, addr_ok is forced to 0 regardless of occupancy.
  - Exercises master back-pressure handling.
- Undefined: no LFSR logic is built; addr_ok follows occupancy only.

Test Plan:
- Write word 0xDEADBEEF at 0x10 accepted in cycle T, then read 0x10 → write data_ok at T+2; read data_ok at T+3 with rdata = 0xDEADBEEF, err = 0.
- Byte write 0xAA at 0x21, then half write 0x1234 at 0x22, onto a word preloaded with 0 → read 0x20 returns 0x1234AA00.
- Read at 0x13 with size = 2, and read at 4*DEPTH_WORDS → each gets data_ok with err = 1, rdata = 0, and the target word is unchanged.
- Hold req high for 8 reads with QUEUE = 4, LATENCY = 4 → addr_ok drops after 4 accepts, and 8 data_ok pulses arrive in request order with matching data.
- Queue 3 writes, pull rst low before any data_ok, release, then read the same addresses → reads return the old values, and no spurious data_ok appears after reset.
- With SRAM_RESPONDER_STALL_EN defined, run 1000 random requests → addr_ok is deasserted on some cycles with queue not full, and all responses match a reference model.

Source files
------------

// File: rtl/sram_responder.sv
// On-chip word memory for the sram bus: in-order responses LATENCY cycles after accept.
// Optional build macro SRAM_RESPONDER_STALL_EN adds LFSR-driven addr_ok back-pressure.
module sram_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned QUEUE       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned PW = (QUEUE > 1) ? $clog2(QUEUE) : 1;
  localparam int unsigned OW = $clog2(QUEUE + 1);
  localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  // Launch happens one cycle before data_ok, so the countdown starts at LATENCY-2.
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : CW'(0);

  typedef struct packed {
    logic          wr;
    logic          err;
    logic [3:0]    be;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
  } entry_t;

  logic [31:0]   mem [DEPTH_WORDS];
  entry_t        q_ent [QUEUE];
  logic [CW-1:0] q_cnt [QUEUE];
  logic [QUEUE-1:0] vld_q, vld_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          run_q;
  logic          data_ok_q, err_q;
  logic [31:0]   rdata_q;
  entry_t        in_ent, rsp_ent;
  logic          accept, push, bypass, launch_head, launch, stall;
  logic [31:0]   wmask;

  // Handshake: a request transfers on a rising edge where req & addr_ok; addr_ok never
  // depends on req. data_ok is a one-cycle strobe with no back-pressure from the master.
`ifdef SRAM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign addr_ok = run_q && (occ_q < OW'(QUEUE)) && !stall;
  assign accept  = req && addr_ok;
  assign bypass  = (LATENCY == 1) && accept;
  assign push    = accept && !bypass;
  assign launch_head = vld_q[rptr_q] && (q_cnt[rptr_q] == '0);
  assign launch  = launch_head || bypass;
  assign rsp_ent = launch_head ? q_ent[rptr_q] : in_ent;
  assign wmask   = {{8{rsp_ent.be[3]}}, {8{rsp_ent.be[2]}}, {8{rsp_ent.be[1]}}, {8{rsp_ent.be[0]}}};

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;
  assign err     = err_q;

  always_comb begin
    in_ent       = '0;
    in_ent.wr    = wr;
    in_ent.wdata = wdata;
    in_ent.idx   = addr[AW+1:2];
    unique case (size)
      2'd0:    in_ent.be = 4'b0001 << addr[1:0];
      2'd1:    in_ent.be = addr[1] ? 4'b1100 : 4'b0011;
      default: in_ent.be = 4'b1111;
    endcase
    in_ent.err = (size == 2'd3) || ((size == 2'd1) && addr[0]) ||
                 ((size == 2'd2) && (addr[1:0] != 2'd0)) ||
                 (addr[31:2] >= 30'(DEPTH_WORDS));
  end

  // Occupancy counts an entry until its data_ok cycle, not just until launch.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    vld_d  = vld_q;
    occ_d  = occ_q + OW'(accept) - OW'(data_ok_q);
    if (push) begin
      vld_d[wptr_q] = 1'b1;
      wptr_d = (wptr_q == PW'(QUEUE - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (launch_head) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d = (rptr_q == PW'(QUEUE - 1)) ? '0 : rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      vld_q     <= '0;
      occ_q     <= '0;
      run_q     <= 1'b0;
      data_ok_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      vld_q     <= vld_d;
      occ_q     <= occ_d;
      run_q     <= 1'b1;
      data_ok_q <= launch;
      if (launch) begin
        err_q   <= rsp_ent.err;
        rdata_q <= (rsp_ent.wr || rsp_ent.err) ? 32'h0 : mem[rsp_ent.idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(QUEUE); i++) begin
      if (push && (wptr_q == PW'(i))) begin
        q_ent[i] <= in_ent;
        q_cnt[i] <= CNT_INIT;
      end else if (q_cnt[i] != '0) begin
        q_cnt[i] <= q_cnt[i] - 1'b1;
      end
    end
  end

  // Writes commit at launch so they become visible exactly in their data_ok cycle.
  always_ff @(posedge clk) begin
    if (launch && rsp_ent.wr && !rsp_ent.err)
      mem[rsp_ent.idx] <= (mem[rsp_ent.idx] & ~wmask) | (rsp_ent.wdata & wmask);
  end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: dut0 with defaults (LATENCY 2), dut1 with LATENCY 4, QUEUE 4.
module tb_sram_responder;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_s [2];
  logic        wr_s [2];
  logic [1:0]  size_s [2];
  logic [31:0] addr_s [2];
  logic [31:0] wdata_s [2];
  logic        addr_ok_s [2];
  logic        data_ok_s [2];
  logic [31:0] rdata_s [2];
  logic        err_s [2];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  rsp_t rq0[$];
  rsp_t rq1[$];
  logic [31:0] exp_q[$];
  int   acc_q[$];
  vec_t vt [18];

  sram_responder u_dut0 (
    .clk(clk), .rst(rst), .req(req_s[0]), .wr(wr_s[0]), .size(size_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .addr_ok(addr_ok_s[0]),
    .data_ok(data_ok_s[0]), .rdata(rdata_s[0]), .err(err_s[0])
  );

  sram_responder #(.DEPTH_WORDS(4096), .LATENCY(4), .QUEUE(4)) u_dut1 (
    .clk(clk), .rst(rst), .req(req_s[1]), .wr(wr_s[1]), .size(size_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .addr_ok(addr_ok_s[1]),
    .data_ok(data_ok_s[1]), .rdata(rdata_s[1]), .err(err_s[1])
  );

  // clock / cycle counter / response collectors
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (data_ok_s[0]) rq0.push_back('{cyc, rdata_s[0], err_s[0]});
    if (data_ok_s[1]) rq1.push_back('{cyc, rdata_s[1], err_s[1]});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 of the cycle after the accept.
  task automatic issue(input int sel, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d, output int acc);
    req_s[sel] = 1'b1; wr_s[sel] = w; size_s[sel] = s; addr_s[sel] = a; wdata_s[sel] = d;
    acc = -1;
    for (int k = 0; k < 100 && acc < 0; k++) begin
      @(negedge clk);
      if (addr_ok_s[sel]) acc = cyc;
      @(posedge clk);
      #1;
    end
    req_s[sel] = 1'b0;
    if (acc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout dut%0d: addr_ok never high, addr %h", sel, a);
    end
  endtask

  task automatic wait_rsp(input int sel, output rsp_t r, output bit ok);
    ok = 1'b0;
    r = '{default: 0};
    for (int k = 0; k < 100 && !ok; k++) begin
      if (sel == 0 && rq0.size() > 0) begin r = rq0.pop_front(); ok = 1'b1; end
      else if (sel == 1 && rq1.size() > 0) begin r = rq1.pop_front(); ok = 1'b1; end
      else begin @(negedge clk); #1; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout dut%0d: got no data_ok expected one within 100 cycles", sel);
    end
  endtask

`ifdef SRAM_RESPONDER_STALL_EN
  logic [31:0] mdl [4096];
  logic [32:0] rexp_q[$];
  int   outst = 0;
  int   stall_seen = 0;
  bit   rnd_phase = 1'b0;

  always @(negedge clk) begin
    if (!rst) outst = 0;
    else begin
      if (rnd_phase && !addr_ok_s[0] && outst < 4) stall_seen++;
      outst = outst + ((req_s[0] && addr_ok_s[0]) ? 1 : 0) - (data_ok_s[0] ? 1 : 0);
    end
  end

  function automatic logic [32:0] model_step(logic w, logic [1:0] s, logic [31:0] a, logic [31:0] d);
    logic [3:0]  be;
    logic [31:0] m;
    if (s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) || a[31:2] >= 30'd4096)
      return {1'b1, 32'h0};
    if (!w) return {1'b0, mdl[a[13:2]]};
    be = (s == 2'd0) ? (4'b0001 << a[1:0]) : (s == 2'd1) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    m  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    mdl[a[13:2]] = (mdl[a[13:2]] & ~m) | (d & m);
    return {1'b0, 32'h0};
  endfunction
`endif

  initial begin
    int   t0, t1, acc, n_acc, drop_at, n_done;
    rsp_t r0, r1;
    bit   ok0, ok1;

    vt[0]  = '{1'b1, 2'd2, 32'h20,   32'h0000_0000, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 2'd0, 32'h21,   32'h0000_AA00, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 2'd1, 32'h22,   32'h1234_0000, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 2'd2, 32'h20,   32'h0,         1'b0, 32'h1234_AA00};
    vt[4]  = '{1'b0, 2'd2, 32'h13,   32'h0,         1'b1, 32'h0};
    vt[5]  = '{1'b0, 2'd2, 32'h4000, 32'h0,         1'b1, 32'h0};
    vt[6]  = '{1'b0, 2'd2, 32'h10,   32'h0,         1'b0, 32'hDEAD_BEEF};
    vt[7]  = '{1'b1, 2'd3, 32'h10,   32'hFFFF_FFFF, 1'b1, 32'h0};
    vt[8]  = '{1'b1, 2'd1, 32'h11,   32'hFFFF_FFFF, 1'b1, 32'h0};
    vt[9]  = '{1'b1, 2'd2, 32'h12,   32'h0,         1'b1, 32'h0};
    vt[10] = '{1'b1, 2'd2, 32'h4010, 32'h1,         1'b1, 32'h0};
    vt[11] = '{1'b0, 2'd0, 32'h13,   32'h0,         1'b0, 32'hDEAD_BEEF};
    vt[12] = '{1'b0, 2'd1, 32'h12,   32'h0,         1'b0, 32'hDEAD_BEEF};
    vt[13] = '{1'b1, 2'd2, 32'h3FFC, 32'h0BAD_F00D, 1'b0, 32'h0};
    vt[14] = '{1'b0, 2'd2, 32'h3FFC, 32'h0,         1'b0, 32'h0BAD_F00D};
    vt[15] = '{1'b1, 2'd0, 32'h20,   32'h0000_0077, 1'b0, 32'h0};
    vt[16] = '{1'b0, 2'd0, 32'h21,   32'h0,         1'b0, 32'h1234_AA77};
    vt[17] = '{1'b0, 2'd3, 32'h20,   32'h0,         1'b1, 32'h0};

    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; wr_s[i] = 1'b0; size_s[i] = 2'd0; addr_s[i] = '0; wdata_s[i] = '0;
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_addr_ok", {31'b0, addr_ok_s[i]}, 32'h0);
      chk("rst_data_ok", {31'b0, data_ok_s[i]}, 32'h0);
      chk("rst_rdata", rdata_s[i], 32'h0);
      chk("rst_err", {31'b0, err_s[i]}, 32'h0);
    end
    #1 rst = 1'b1;
    #1 chk("addr_ok_before_first_edge", {31'b0, addr_ok_s[0]}, 32'h0);
    sync();

    // pipelined write then read, LATENCY 2
    issue(0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, t0);
    issue(0, 1'b0, 2'd2, 32'h10, 32'h0, t1);
`ifndef SRAM_RESPONDER_STALL_EN
    chk("b2b_accept", t1 - t0, 32'd1);
`endif
    wait_rsp(0, r0, ok0);
    wait_rsp(0, r1, ok1);
    if (ok0 && ok1) begin
      chk("wr_lat", r0.cyc - t0, 32'd2);
      chk("wr_err", {31'b0, r0.err}, 32'h0);
      chk("wr_rdata", r0.rdata, 32'h0);
      chk("rd_lat", r1.cyc - t1, 32'd2);
      chk("rd_err", {31'b0, r1.err}, 32'h0);
      chk("rd_rdata", r1.rdata, 32'hDEAD_BEEF);
    end

    // directed vector table on dut0
    for (int i = 0; i < 18; i++) begin
      sync();
      issue(0, vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, acc);
      wait_rsp(0, r0, ok0);
      if (ok0) begin
        chk($sformatf("vec%0d_err", i), {31'b0, r0.err}, {31'b0, vt[i].exp_err});
        chk($sformatf("vec%0d_rdata", i), r0.rdata, vt[i].exp_rdata);
        chk($sformatf("vec%0d_lat", i), r0.cyc - acc, 32'd2);
        @(negedge clk);
        chk($sformatf("vec%0d_dok_pulse", i), {31'b0, data_ok_s[0]}, 32'h0);
        chk($sformatf("vec%0d_rdata_hold", i), rdata_s[0], vt[i].exp_rdata);
      end
    end

    // dut1: preload, then 8 pipelined reads against a 4-deep queue
    for (int i = 0; i < 8; i++) begin
      sync();
      issue(1, 1'b1, 2'd2, 32'h100 + 4 * i, 32'hB000_0000 + i, acc);
      wait_rsp(1, r0, ok0);
      if (ok0) chk("b_pre_err", {31'b0, r0.err}, 32'h0);
    end
    sync();
    n_acc = 0;
    drop_at = -1;
    req_s[1] = 1'b1; wr_s[1] = 1'b0; size_s[1] = 2'd2; addr_s[1] = 32'h100;
    for (int k = 0; k < 100 && n_acc < 8; k++) begin
      @(negedge clk);
      if (addr_ok_s[1]) begin
        exp_q.push_back(32'hB000_0000 + n_acc);
        acc_q.push_back(cyc);
        n_acc++;
      end else if (drop_at < 0) drop_at = n_acc;
      @(posedge clk);
      #1;
      addr_s[1] = 32'h100 + 4 * n_acc;
    end
    req_s[1] = 1'b0;
    chk("b_accepts", n_acc, 32'd8);
`ifndef SRAM_RESPONDER_STALL_EN
    chk("b_full_drop_after", drop_at, 32'd4);
`endif
    for (int i = 0; i < 8; i++) begin
      wait_rsp(1, r0, ok0);
      if (ok0 && exp_q.size() > 0) begin
        chk($sformatf("b_rd%0d_rdata", i), r0.rdata, exp_q.pop_front());
        chk($sformatf("b_rd%0d_err", i), {31'b0, r0.err}, 32'h0);
        chk($sformatf("b_rd%0d_lat", i), r0.cyc - acc_q.pop_front(), 32'd4);
      end
    end

    // reset with three writes in flight: none may commit or respond
    sync();
    for (int i = 0; i < 3; i++) issue(1, 1'b1, 2'd2, 32'h100 + 4 * i, 32'h5555_0000 + i, acc);
    n_done = rq1.size();
    rst = 1'b0;
`ifndef SRAM_RESPONDER_STALL_EN
    chk("rst_no_rsp_before", n_done, 32'd0);
`endif
    @(negedge clk);
    chk("rst_mid_rdata", rdata_s[1], 32'h0);
    chk("rst_mid_data_ok", {31'b0, data_ok_s[1]}, 32'h0);
    chk("rst_mid_addr_ok", {31'b0, addr_ok_s[1]}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_release_addr_ok", {31'b0, addr_ok_s[1]}, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_spurious_dut1", rq1.size(), n_done);
    chk("rst_no_spurious_dut0", rq0.size(), 32'd0);
    for (int i = 0; i < n_done; i++) void'(rq1.pop_front());
    for (int i = 0; i < 3; i++) begin
      sync();
      issue(1, 1'b0, 2'd2, 32'h100 + 4 * i, 32'h0, acc);
      wait_rsp(1, r0, ok0);
      if (ok0) chk($sformatf("rst_old%0d", i), r0.rdata,
                   (i < n_done) ? 32'h5555_0000 + i : 32'hB000_0000 + i);
    end

`ifdef SRAM_RESPONDER_STALL_EN
    // random traffic against the reference model under back-pressure
    for (int i = 0; i < 32; i++) begin
      sync();
      issue(0, 1'b1, 2'd2, 32'h200 + 4 * i, 32'hC000_0000 + i, acc);
      void'(model_step(1'b1, 2'd2, 32'h200 + 4 * i, 32'hC000_0000 + i));
      wait_rsp(0, r0, ok0);
    end
    sync();
    rnd_phase = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic        w;
      logic [1:0]  s;
      logic [31:0] a, d;
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 9) == 0) ? 32'h4000 + 4 * $urandom_range(0, 15)
                                      : 32'h200 + $urandom_range(0, 127);
      d = $urandom;
      issue(0, w, s, a, d, acc);
      rexp_q.push_back(model_step(w, s, a, d));
    end
    rnd_phase = 1'b0;
    chk("stall_seen", {31'b0, stall_seen > 0}, 32'h1);
    for (int i = 0; i < 1000; i++) begin
      logic [32:0] e;
      wait_rsp(0, r0, ok0);
      if (!ok0) break;
      e = rexp_q.pop_front();
      chk($sformatf("rnd%0d_err", i), {31'b0, r0.err}, {31'b0, e[32]});
      chk($sformatf("rnd%0d_rdata", i), r0.rdata, e[31:0]);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
